fn_sw_arbiter: RTL and testbench

Round-robin scheduler that shares one `fn_sw` 2-bit function selector between N requesters. Each requester presents operand bits `a`, `b` and a 2-bit function select. The arbiter grants one requester at a time, drives the shared `fn_sw` instance from registered operands, captures `y`, and returns it with the requester ID over a valid/ready response port. It sits between the requesting control blocks and the single `fn_sw` datapath.

---
 rtl/fn_sw_pkg.sv | 17 +
 rtl/fn_sw.sv | 27 ++
 rtl/fn_sw_arbiter_rr_pick.sv | 43 ++++
 rtl/fn_sw_arbiter.sv | 149 ++++++++++++++
 tb/tb_fn_sw_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fn_sw_pkg.sv
// fn_sw_pkg
//   Shared definitions for the fn_sw datapath and its round-robin arbiter:
//   arbiter FSM state encoding and the 2-bit function select codes.
package fn_sw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] FN_AND  = 2'b00;
    localparam logic [1:0] FN_OR   = 2'b01;
    localparam logic [1:0] FN_XOR  = 2'b10;
    localparam logic [1:0] FN_XNOR = 2'b11;

endpackage

// File: rtl/fn_sw.sv
// fn_sw
//   Combinational 2-bit function selector.
//   Ports:
//     a, b : operand bits
//     sel  : function select (AND / OR / XOR / XNOR)
//     y    : result
module fn_sw
    import fn_sw_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [1:0] sel,
    output logic       y
);

    always_comb begin
        y = 1'b0;
        case (sel)
            FN_AND:  y = a & b;
            FN_OR:   y = a | b;
            FN_XOR:  y = a ^ b;
            FN_XNOR: y = ~(a ^ b);
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/fn_sw_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin priority encoder: returns the first set bit of
//   req at or after ptr, searching upward and wrapping modulo N_REQ.
//   Ports:
//     req    : request vector
//     ptr    : highest-priority index for this search
//     gnt_id : index of the selected requester (0 when none)
//     any    : at least one request bit is set
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  gnt_id,
    output logic             any
);

    // Distance of each requester from ptr going upward with wrap; the
    // smallest distance among active requests wins.
    logic [ID_W:0] w_dist;
    logic [ID_W:0] w_best;

    always_comb begin
        gnt_id = '0;
        any    = 1'b0;
        w_dist = '0;
        w_best = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if ((ID_W+1)'(j) >= {1'b0, ptr}) begin
                w_dist = (ID_W+1)'(j) - {1'b0, ptr};
            end else begin
                w_dist = (ID_W+1)'(j) + (ID_W+1)'(N_REQ) - {1'b0, ptr};
            end
            if (req[j] && (!any || (w_dist < w_best))) begin
                any    = 1'b1;
                w_best = w_dist;
                gnt_id = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/fn_sw_arbiter.sv
// fn_sw_arbiter
//   Round-robin scheduler sharing one fn_sw instance between N_REQ
//   requesters. A grant latches the requester's operands, the next cycle
//   evaluates fn_sw on the latched copy, and the result is returned with the
//   requester ID over a valid/ready response port.
//   Ports:
//     clk, rst_n : clock (rising edge), asynchronous active-low reset
//     req        : per-requester request level
//     a_in, b_in : per-requester operand bits
//     sel_in     : per-requester function select, bits [2i+1:2i]
//     ack        : one-hot marker of the requester owning the response
//     rsp_valid  : response valid
//     rsp_ready  : response consumer ready
//     rsp_y      : fn_sw result
//     rsp_id     : granted requester index
//     busy       : high whenever the FSM is not idle
module fn_sw_arbiter
    import fn_sw_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     a_in,
    input  logic [N_REQ-1:0]     b_in,
    input  logic [2*N_REQ-1:0]   sel_in,
    output logic [N_REQ-1:0]     ack,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_y,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 busy
);

    state_t             r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_gnt_id;
    logic               r_op_a;
    logic               r_op_b;
    logic [1:0]         r_op_sel;
    logic               r_rsp_y;
    logic [ID_W-1:0]    r_rsp_id;
    logic               r_rsp_valid;
    logic [N_REQ-1:0]   r_ack;
    logic               r_busy;

    logic               w_any;
    logic [ID_W-1:0]    w_pick;
    logic               w_pick_a;
    logic               w_pick_b;
    logic [1:0]         w_pick_sel;
    logic               w_y;
    logic [ID_W-1:0]    w_ptr_next;
    logic [N_REQ-1:0]   w_gnt_onehot;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (r_ptr),
        .gnt_id (w_pick),
        .any    (w_any)
    );

    // Operands of the requester that would be granted this cycle.
    always_comb begin
        w_pick_a   = 1'b0;
        w_pick_b   = 1'b0;
        w_pick_sel = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (w_pick == ID_W'(k)) begin
                w_pick_a   = a_in[k];
                w_pick_b   = b_in[k];
                w_pick_sel = sel_in[2*k +: 2];
            end
        end
    end

    // The datapath only ever sees the latched operand copy, so requesters
    // may change or drop their inputs once the grant has been taken.
    fn_sw u_fn_sw (
        .a   (r_op_a),
        .b   (r_op_b),
        .sel (r_op_sel),
        .y   (w_y)
    );

    assign w_ptr_next   = (r_gnt_id == ID_W'(N_REQ - 1)) ? '0 : r_gnt_id + ID_W'(1);
    assign w_gnt_onehot = N_REQ'(1) << r_gnt_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_gnt_id    <= '0;
            r_op_a      <= 1'b0;
            r_op_b      <= 1'b0;
            r_op_sel    <= '0;
            r_rsp_y     <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_valid <= 1'b0;
            r_ack       <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_op_a   <= w_pick_a;
                        r_op_b   <= w_pick_b;
                        r_op_sel <= w_pick_sel;
                        r_gnt_id <= w_pick;
                        r_busy   <= 1'b1;
                        r_state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_rsp_y     <= w_y;
                    r_rsp_id    <= r_gnt_id;
                    r_ack       <= w_gnt_onehot;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    // Response held stable until the consumer accepts it.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ack       <= '0;
                        r_busy      <= 1'b0;
                        r_ptr       <= w_ptr_next;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack       = r_ack;
    assign rsp_valid = r_rsp_valid;
    assign rsp_y     = r_rsp_y;
    assign rsp_id    = r_rsp_id;
    assign busy      = r_busy;

endmodule

// File: tb/tb_fn_sw_arbiter.sv
module tb_fn_sw_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] a_in = '0;
    logic [3:0] b_in = '0;
    logic [7:0] sel_in = '0;
    logic       rsp_ready = 1'b1;
    logic [3:0] ack;
    logic       rsp_valid;
    logic       rsp_y;
    logic [1:0] rsp_id;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] id;
        logic       y;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    fn_sw_arbiter #(
        .N_REQ (4),
        .ID_W  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .sel_in    (sel_in),
        .ack       (ack),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    function automatic logic fn_model(input logic a, input logic b, input logic [1:0] s);
        case (s)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a ^ b);
        endcase
    endfunction

    function automatic void expect_rsp(input logic [1:0] id, input logic y);
        sb.push_back(exp_t'{id: id, y: y});
    endfunction

    task automatic set_op(input int i, input logic a, input logic b, input logic [1:0] s);
        a_in[i] = a;
        b_in[i] = b;
        sel_in[2*i +: 2] = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted response is matched against the queue.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got id=%0d y=%b ack=%b want none", rsp_id, rsp_y, ack);
            end else begin
                mon_e = sb.pop_front();
                if (rsp_id !== mon_e.id || rsp_y !== mon_e.y || ack !== (4'b0001 << mon_e.id)) begin
                    errors++;
                    $display("FAIL sb_rsp got id=%0d y=%b ack=%b want id=%0d y=%b ack=%b",
                             rsp_id, rsp_y, ack, mon_e.id, mon_e.y, 4'b0001 << mon_e.id);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rsp_valid, busy, rsp_y} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got valid/busy/y=%b want 000", {rsp_valid, busy, rsp_y});
        end
        checks++;
        if (ack !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ack got %b want 0000", ack);
        end
        checks++;
        if (rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_id got %0d want 0", rsp_id);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        set_op(2, 1'b1, 1'b0, 2'b10);
        req = 4'b0100;
        rsp_ready = 1'b1;
        expect_rsp(2'd2, 1'b1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pre got busy=%b valid=%b want 0 0", busy, rsp_valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_exec got busy=%b valid=%b want 1 0", busy, rsp_valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_y !== 1'b1 || rsp_id !== 2'd2 || ack !== 4'b0100) begin
            errors++;
            $display("FAIL single_done got valid=%b y=%b id=%0d ack=%b want 1 1 2 0100",
                     rsp_valid, rsp_y, rsp_id, ack);
        end
        tick();
        req = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle got busy=%b valid=%b want 0 0", busy, rsp_valid);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL single_drain got %0d pending want 0", sb.size());
        end
        tick();
    endtask

    task automatic test_reset_mid_exec();
        logic seen;
        set_op(0, 1'b1, 1'b1, 2'b00);
        req = 4'b0001;
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_exec got busy=%b valid=%b want 1 0", busy, rsp_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, busy, rsp_y} !== 3'b000 || ack !== 4'b0000 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL midrst_outputs got valid=%b busy=%b y=%b ack=%b id=%0d want all 0",
                     rsp_valid, busy, rsp_y, ack, rsp_id);
        end
        req = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid || busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midrst_quiet got activity=%b want 0", seen);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL midrst_drain got %0d pending want 0", sb.size());
        end
        tick();
    endtask

    task automatic test_all_rr();
        int vc[5];
        int n;
        int c;
        a_in = 4'b1010;
        b_in = 4'b0110;
        sel_in = {2'b11, 2'b10, 2'b01, 2'b00};
        for (int i = 0; i < 4; i++) expect_rsp(2'(i), fn_model(a_in[i], b_in[i], sel_in[2*i +: 2]));
        expect_rsp(2'd0, fn_model(a_in[0], b_in[0], sel_in[1:0]));
        rsp_ready = 1'b1;
        req = 4'b1111;
        n = 0;
        c = 0;
        while (n < 5 && c < 40) begin
            @(negedge clk);
            c++;
            if (rsp_valid) begin
                vc[n] = c;
                n++;
            end
            tick();
        end
        req = '0;
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL rr_count got %0d responses want 5", n);
        end else begin
            checks++;
            if (vc[0] != 3) begin
                errors++;
                $display("FAIL rr_latency got cycle %0d want 3", vc[0]);
            end
            for (int i = 1; i < 5; i++) begin
                checks++;
                if (vc[i] - vc[i-1] != 3) begin
                    errors++;
                    $display("FAIL rr_spacing idx=%0d got %0d want 3", i, vc[i] - vc[i-1]);
                end
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_drain got pending=%0d busy=%b want 0 0", sb.size(), busy);
        end
        tick();
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        set_op(1, 1'b0, 1'b1, 2'b00);
        set_op(3, 1'b1, 1'b1, 2'b01);
        req = 4'b1010;
        expect_rsp(2'd1, 1'b0);
        expect_rsp(2'd3, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_wait got valid=%b want 1", rsp_valid);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_y !== 1'b0 || ack !== 4'b0010 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_stall cyc=%0d got valid=%b id=%0d y=%b ack=%b busy=%b want 1 1 0 0010 1",
                         k, rsp_valid, rsp_id, rsp_y, ack, busy);
            end
        end
        tick();
        rsp_ready = 1'b1;
        tick();
        req = 4'b1000;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_handshake got valid=%b want 0", rsp_valid);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3) begin
            errors++;
            $display("FAIL bp_next got valid=%b id=%0d want 1 3", rsp_valid, rsp_id);
        end
        tick();
        req = '0;
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL bp_drain got %0d pending want 0", sb.size());
        end
        tick();
    endtask

    task automatic test_operand_change();
        set_op(1, 1'b1, 1'b1, 2'b00);
        req = 4'b0010;
        expect_rsp(2'd1, 1'b1);
        tick();
        a_in[1] = 1'b0;
        b_in[1] = 1'b0;
        sel_in[3:2] = 2'b10;
        req = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL opchg_busy got %b want 1", busy);
        end
        for (int k = 0; k < 10; k++) begin
            if (rsp_valid) break;
            @(negedge clk);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_y !== 1'b1) begin
            errors++;
            $display("FAIL opchg_done got valid=%b y=%b want 1 1", rsp_valid, rsp_y);
        end
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL opchg_drain got busy=%b pending=%0d want 0 0", busy, sb.size());
        end
        tick();
    endtask

    task automatic test_wrap_skip();
        int n;
        int c;
        set_op(2, 1'b1, 1'b1, 2'b10);
        req = 4'b0100;
        expect_rsp(2'd2, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin
            errors++;
            $display("FAIL wrap_setup got valid=%b id=%0d want 1 2", rsp_valid, rsp_id);
        end
        set_op(3, 1'b0, 1'b0, 2'b11);
        set_op(1, 1'b0, 1'b0, 2'b01);
        expect_rsp(2'd3, 1'b1);
        expect_rsp(2'd1, 1'b0);
        expect_rsp(2'd3, 1'b1);
        tick();
        req = 4'b1010;
        n = 0;
        c = 0;
        while (n < 3 && c < 30) begin
            @(negedge clk);
            c++;
            if (rsp_valid) n++;
            tick();
        end
        req = '0;
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL wrap_count got %0d responses want 3", n);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL wrap_drain got %0d pending want 0", sb.size());
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_mid_exec();
        test_all_rr();
        test_backpressure();
        test_operand_change();
        test_wrap_skip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
